// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// Holds the FSM and grant encodings plus the arbitration helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GrantIf = 1'b0,
    GrantD  = 1'b1
  } grant_t;

  localparam int unsigned DEF_WAIT_LIMIT = 16;

  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // A contested grant goes to the port that did not complete last, so the two ports alternate.
  function automatic grant_t pick_grant(input logic if_req, input logic d_req, input grant_t last);
    grant_t g;
    if (if_req && d_req) begin
      g = (last == GrantD) ? GrantIf : GrantD;
    end else if (d_req) begin
      g = GrantD;
    end else begin
      g = GrantIf;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Wishbone-classic memory port shared by the arbiter and the external RAM.
interface mem_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cyc, stb, we, sel, addr, wdata, input rdata, ack);
  modport slave  (input cyc, stb, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one Wishbone memory port between instruction fetch and the MEM stage,
// sequencing each request into a registered bus cycle with a one-cycle response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [31:0]         if_addr_i,
  output logic [31:0]         if_data_o,
  output logic                if_ack_o,
  input  logic                d_ce_i,
  input  logic                d_we_i,
  input  logic [3:0]          d_sel_i,
  input  logic [31:0]         d_addr_i,
  input  logic [31:0]         d_data_i,
  output logic [31:0]         d_data_o,
  output logic                d_ack_o,
  mem_arbiter_if.master       bus,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o,
  output logic                timeout_o
);

  localparam logic [7:0] WaitLimitC = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  grant_t      last_grant_q, last_grant_d;
  grant_t      pick_s;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_data_q, d_data_d;
  logic        timeout_q, timeout_d;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_data_d    = if_data_q;
    d_data_d     = d_data_q;
    timeout_d    = timeout_q;
    pick_s       = pick_grant(if_ce_i, d_ce_i, last_grant_q);

    case (state_q)
      IDLE: begin
        if ((if_ce_i == ChipEnable) || (d_ce_i == ChipEnable)) begin
          grant_d    = pick_s;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = ACCESS;
          if (pick_s == GrantD) begin
            we_d    = d_we_i;
            sel_d   = d_sel_i;
            addr_d  = d_addr_i;
            wdata_d = d_data_i;
          end else begin
            we_d    = ~WriteEnable;
            sel_d   = 4'b1111;
            addr_d  = if_addr_i;
            wdata_d = ZeroWord;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (bus.ack) begin
          if (grant_q == GrantD) begin
            d_data_d = bus.rdata;
          end else begin
            if_data_d = bus.rdata;
          end
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          last_grant_d = grant_q;
          state_d      = RESP;
        end else if (wait_cnt_q == WaitLimitC) begin
          // Abort: the requester still gets its ack, carrying zero data.
          if (grant_q == GrantD) begin
            d_data_d = ZeroWord;
          end else begin
            if_data_d = ZeroWord;
          end
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single register bank for FSM state and all registered bus/response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= GrantIf;
      last_grant_q <= GrantIf;
      wait_cnt_q   <= 8'd0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'b0000;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      if_data_q    <= 32'h0000_0000;
      d_data_q     <= 32'h0000_0000;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_data_q    <= if_data_d;
      d_data_q     <= d_data_d;
      timeout_q    <= timeout_d;
    end
  end

  // A flushed requester (ce dropped) silently loses its response.
  assign if_ack_o = (state_q == RESP) && (grant_q == GrantIf) && if_ce_i;
  assign d_ack_o  = (state_q == RESP) && (grant_q == GrantD) && d_ce_i;

  assign if_data_o = if_data_q;
  assign d_data_o  = d_data_q;
  assign timeout_o = timeout_q;

  assign stallreq_if_o  = rst & if_ce_i & ~if_ack_o;
  assign stallreq_mem_o = rst & d_ce_i & ~d_ack_o;

  assign bus.cyc   = cyc_q;
  assign bus.stb   = stb_q;
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with WAIT_LIMIT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        d_ce_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_sel_i = 4'h0;
  logic [31:0] d_addr_i = 32'h0;
  logic [31:0] d_data_i = 32'h0;
  logic [31:0] d_data_o;
  logic        d_ack_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        timeout_o;

  int checks = 0;
  int failures = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_ack_o       (if_ack_o),
    .d_ce_i         (d_ce_i),
    .d_we_i         (d_we_i),
    .d_sel_i        (d_sel_i),
    .d_addr_i       (d_addr_i),
    .d_data_i       (d_data_i),
    .d_data_o       (d_data_o),
    .d_ack_o        (d_ack_o),
    .bus            (bus),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_ce;  logic [31:0] if_addr;
    logic        d_ce;   logic d_we; logic [3:0] d_sel; logic [31:0] d_addr; logic [31:0] d_wdata;
    logic        ack;    logic [31:0] rdata;
    logic        cyc;    logic e_we; logic [3:0] e_sel; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic        if_ack; logic [31:0] if_data;
    logic        d_ack;  logic d_chk; logic [31:0] d_data;
    logic        st_if;  logic st_mem; logic tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // simultaneous pair after reset: D first, then IF; a second pair repeats D, IF
    vecs.push_back('{1'b1,32'h0,   1'b1,1'b0,4'hF,32'h40,32'h0, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,32'h0,   1'b1,1'b0,4'hF,32'h40,32'h0, 1'b1,32'h11111111, 1'b1,1'b0,4'hF,32'h40,32'h0,  1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,32'h0,   1'b1,1'b0,4'hF,32'h40,32'h0, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b1,1'b1,32'h11111111, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b1,32'h22222222, 1'b1,1'b0,4'hF,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b1,32'h22222222, 1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b1,1'b0,4'hF,32'h44,32'h0, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b1,1'b0,4'hF,32'h44,32'h0, 1'b1,32'h33333333, 1'b1,1'b0,4'hF,32'h44,32'h0,  1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b1,1'b0,4'hF,32'h44,32'h0, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b1,1'b1,32'h33333333, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b1,32'h44444444, 1'b1,1'b0,4'hF,32'h8,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h8,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b1,32'h44444444, 1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    // single load acked on its first stb cycle
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,       1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h100,32'h0, 1'b1,32'hDEADBEEF,1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,       1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b1,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    // store with three wait cycles, then a stray bus ack while idle
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b1,4'h4,32'h200,32'h00AA0000, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,           1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0,32'h0, 1'b1,1'b1,4'h4,32'h200,32'h00AA0000, 1'b0,32'h0,        1'b1,1'b1,4'h4,32'h200,32'h00AA0000,  1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b1,4'h4,32'h200,32'h00AA0000, 1'b1,32'h12345678, 1'b1,1'b1,4'h4,32'h200,32'h00AA0000,  1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b1,4'h4,32'h200,32'h00AA0000, 1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,           1'b0,32'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b1,32'h99999999, 1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0});
    // fetch that never gets a bus ack: stb high for WAIT_LIMIT+1 = 5 cycles
    vecs.push_back('{1'b1,32'h300, 1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b1,32'h300, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,       1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,32'h300, 1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b1,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});
    // fetch flushed mid-access, then a load shows the FSM is back in IDLE
    vecs.push_back('{1'b1,32'h400, 1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b1,1'b0,4'hF,32'h400,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b1,32'h55555555, 1'b1,1'b0,4'hF,32'h400,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,32'h0,       1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h500,32'h0, 1'b1,32'h66666666,1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,32'h0,       1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b1,1'b1,32'h66666666, 1'b0,1'b0,1'b1});
    vecs.push_back('{1'b0,32'h0,   1'b0,1'b0,4'h0,32'h0,32'h0,  1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1});

    bus.ack   = 1'b0;
    bus.rdata = 32'h0;

    // reset state, with both requests high to show the stalls are masked
    if_ce_i = 1'b1;
    d_ce_i  = 1'b1;
    #12;
    chk("rst cyc", 32'(bus.cyc), 32'h0);
    chk("rst stb", 32'(bus.stb), 32'h0);
    chk("rst addr", bus.addr, 32'h0);
    chk("rst if_ack", 32'(if_ack_o), 32'h0);
    chk("rst d_ack", 32'(d_ack_o), 32'h0);
    chk("rst stall_if", 32'(stallreq_if_o), 32'h0);
    chk("rst stall_mem", 32'(stallreq_mem_o), 32'h0);
    chk("rst timeout", 32'(timeout_o), 32'h0);
    if_ce_i = 1'b0;
    d_ce_i  = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if_ce_i   = vecs[i].if_ce;
      if_addr_i = vecs[i].if_addr;
      d_ce_i    = vecs[i].d_ce;
      d_we_i    = vecs[i].d_we;
      d_sel_i   = vecs[i].d_sel;
      d_addr_i  = vecs[i].d_addr;
      d_data_i  = vecs[i].d_wdata;
      bus.ack   = vecs[i].ack;
      bus.rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("r%0d cyc", i), 32'(bus.cyc), 32'(vecs[i].cyc));
      chk($sformatf("r%0d stb", i), 32'(bus.stb), 32'(vecs[i].cyc));
      if (vecs[i].cyc) begin
        chk($sformatf("r%0d we", i), 32'(bus.we), 32'(vecs[i].e_we));
        chk($sformatf("r%0d sel", i), 32'(bus.sel), 32'(vecs[i].e_sel));
        chk($sformatf("r%0d addr", i), bus.addr, vecs[i].e_addr);
        chk($sformatf("r%0d wdata", i), bus.wdata, vecs[i].e_wdata);
      end
      chk($sformatf("r%0d if_ack", i), 32'(if_ack_o), 32'(vecs[i].if_ack));
      if (vecs[i].if_ack) chk($sformatf("r%0d if_data", i), if_data_o, vecs[i].if_data);
      chk($sformatf("r%0d d_ack", i), 32'(d_ack_o), 32'(vecs[i].d_ack));
      if (vecs[i].d_chk) chk($sformatf("r%0d d_data", i), d_data_o, vecs[i].d_data);
      chk($sformatf("r%0d stall_if", i), 32'(stallreq_if_o), 32'(vecs[i].st_if));
      chk($sformatf("r%0d stall_mem", i), 32'(stallreq_mem_o), 32'(vecs[i].st_mem));
      chk($sformatf("r%0d timeout", i), 32'(timeout_o), 32'(vecs[i].tmo));
    end

    // reset asserted mid-access clears the bus cycle and sticky timeout at once
    @(posedge clk);
    #1;
    bus.ack   = 1'b0;
    if_ce_i   = 1'b1;
    if_addr_i = 32'h600;
    @(posedge clk);
    #1;
    chk("mid pre cyc", 32'(bus.cyc), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid rst cyc", 32'(bus.cyc), 32'h0);
    chk("mid rst stb", 32'(bus.stb), 32'h0);
    chk("mid rst if_ack", 32'(if_ack_o), 32'h0);
    chk("mid rst d_ack", 32'(d_ack_o), 32'h0);
    chk("mid rst timeout", 32'(timeout_o), 32'h0);
    chk("mid rst stall_if", 32'(stallreq_if_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.cyc && n < 8) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("post rst cyc", 32'(bus.cyc), 32'h1);
      chk("post rst addr", bus.addr, 32'h600);
      bus.ack   = 1'b1;
      bus.rdata = 32'h77777777;
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
      chk("post rst if_ack", 32'(if_ack_o), 32'h1);
      chk("post rst if_data", if_data_o, 32'h77777777);
      if_ce_i = 1'b0;
      @(posedge clk);
      #1;
      chk("post rst idle ack", 32'(if_ack_o), 32'h0);
      chk("post rst idle cyc", 32'(bus.cyc), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
